regfile_wb_queue: RTL and testbench

//  Write-back initiator for the 32x32 register file (2 read / 1 write, r0 hardwired 0).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_queue_if.sv | 44 ++++
 rtl/wb_fifo.sv | 62 ++++++
 rtl/regfile_wb_queue.sv | 121 ++++++++++++
 tb/tb_regfile_wb_queue.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address/data widths, the hardwired zero register
// and the write-back payload carried through the queue.
package regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer, regfile-write and forward-query signals of the write-back queue.
// The master side belongs to the producers/decode, the slave side to the queue.
interface regfile_wb_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import regfile_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_waddr;
    logic [REG_DW-1:0] mem_wdata;
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_waddr;
    logic [REG_DW-1:0] alu_wdata;
    logic              rf_busy;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_waddr;
    logic [REG_DW-1:0] rf_wdata;
    logic [REG_AW-1:0] q_addr1;
    logic              q_hit1;
    logic [REG_DW-1:0] q_data1;
    logic [REG_AW-1:0] q_addr2;
    logic              q_hit2;
    logic [REG_DW-1:0] q_data2;
    logic [CW-1:0]     count;

    modport master (
        output mem_valid, mem_waddr, mem_wdata, alu_valid, alu_waddr, alu_wdata,
               rf_busy, q_addr1, q_addr2,
        input  mem_ready, alu_ready, rf_wen, rf_waddr, rf_wdata,
               q_hit1, q_data1, q_hit2, q_data2, count
    );

    modport slave (
        input  mem_valid, mem_waddr, mem_wdata, alu_valid, alu_waddr, alu_wdata,
               rf_busy, q_addr1, q_addr2,
        output mem_ready, alu_ready, rf_wen, rf_waddr, rf_wdata,
               q_hit1, q_data1, q_hit2, q_data2, count
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order write-back storage: up to two pushes (a older than b) and one pop per cycle.
// Entries are presented oldest-first so the forwarding search can pick the youngest match.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_a_i,
    input  wb_entry_t        data_a_i,
    input  logic             push_b_i,
    input  wb_entry_t        data_b_i,
    input  logic             pop_i,
    output wb_entry_t        ent_o [DEPTH],
    output logic [DEPTH-1:0] vld_o,
    output logic [CW-1:0]    count_o
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_b;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_b = push_a_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_a_i) mem_q[wr_ptr_q] <= data_a_i;
        if (push_b_i) mem_q[wr_ptr_b] <= data_b_i;
    end

    // Slot k of the view is the k-th oldest entry; ent_o[0] is the head.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ent_o[k] = mem_q[rd_ptr_q + PW'(k)];
            vld_o[k] = CW'(k) < count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back initiator: merges mem and ALU results through an in-order queue into the
// single regfile write port and forwards the youngest pending value to decode.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_queue_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t         mem_e, alu_e;
    wb_entry_t         ent [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [CW-1:0]     count, free;
    logic              mem_zero, alu_zero, mem_rdy, alu_rdy, mem_push, alu_push, pop;
    logic              rf_wen_q, rf_wen_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [REG_DW-1:0] rf_wdata_q, rf_wdata_d;
    logic              hit1, hit2;
    logic [REG_DW-1:0] data1, data2;

    // Zero-destination results are swallowed; free space ignores a same-cycle pop.
    always_comb begin
        mem_e    = '{addr: bus.mem_waddr, data: bus.mem_wdata};
        alu_e    = '{addr: bus.alu_waddr, data: bus.alu_wdata};
        free     = CW'(DEPTH) - count;
        mem_zero = bus.mem_waddr == REG_ZERO;
        alu_zero = bus.alu_waddr == REG_ZERO;
        mem_rdy  = mem_zero || (free != '0);
        alu_rdy  = alu_zero || (free >= CW'(2)) ||
                   ((free == CW'(1)) && !(bus.mem_valid && !mem_zero));
        mem_push = bus.mem_valid && mem_rdy && !mem_zero;
        alu_push = bus.alu_valid && alu_rdy && !alu_zero;
        pop      = (count != '0) && !bus.rf_busy;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_a_i (mem_push),
        .data_a_i (mem_e),
        .push_b_i (alu_push),
        .data_b_i (alu_e),
        .pop_i    (pop),
        .ent_o    (ent),
        .vld_o    (vld),
        .count_o  (count)
    );

    always_comb begin
        rf_wen_d   = pop;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pop) begin
            rf_waddr_d = ent[0].addr;
            rf_wdata_d = ent[0].data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Output stage is the oldest candidate; queue entries scanned oldest-first so the youngest wins.
    always_comb begin
        hit1  = 1'b0;
        data1 = '0;
        hit2  = 1'b0;
        data2 = '0;
        if (rf_wen_q && (rf_waddr_q == bus.q_addr1)) begin
            hit1  = 1'b1;
            data1 = rf_wdata_q;
        end
        if (rf_wen_q && (rf_waddr_q == bus.q_addr2)) begin
            hit2  = 1'b1;
            data2 = rf_wdata_q;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (vld[k] && (ent[k].addr == bus.q_addr1)) begin
                hit1  = 1'b1;
                data1 = ent[k].data;
            end
            if (vld[k] && (ent[k].addr == bus.q_addr2)) begin
                hit2  = 1'b1;
                data2 = ent[k].data;
            end
        end
        if (bus.q_addr1 == REG_ZERO) begin
            hit1  = 1'b0;
            data1 = '0;
        end
        if (bus.q_addr2 == REG_ZERO) begin
            hit2  = 1'b0;
            data2 = '0;
        end
    end

    assign bus.mem_ready = mem_rdy;
    assign bus.alu_ready = alu_rdy;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.q_hit1    = hit1;
    assign bus.q_data1   = data1;
    assign bus.q_hit2    = hit2;
    assign bus.q_data2   = data2;
    assign bus.count     = count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vector table and reset sequence on DEPTH=4,
// then random traffic on DEPTH=2/4/8 against a queue-based reference model.
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int NI   = 3;
    localparam int DIR  = 1;
    localparam int NROW = 24;
    localparam int NCYC = 10000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mem_valid [NI];
    logic [4:0]  mem_waddr [NI];
    logic [31:0] mem_wdata [NI];
    logic        alu_valid [NI];
    logic [4:0]  alu_waddr [NI];
    logic [31:0] alu_wdata [NI];
    logic        rf_busy   [NI];
    logic [4:0]  q_addr1   [NI];
    logic [4:0]  q_addr2   [NI];

    logic [NI-1:0]        mem_ready, alu_ready, rf_wen, q_hit1, q_hit2;
    logic [NI-1:0][4:0]   rf_waddr;
    logic [NI-1:0][31:0]  rf_wdata, q_data1, q_data2;
    logic [NI-1:0][3:0]   count;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 2 : (g == 1) ? 4 : 8;
        regfile_wb_queue_if #(.DEPTH(D)) bus ();
        assign bus.mem_valid = mem_valid[g];
        assign bus.mem_waddr = mem_waddr[g];
        assign bus.mem_wdata = mem_wdata[g];
        assign bus.alu_valid = alu_valid[g];
        assign bus.alu_waddr = alu_waddr[g];
        assign bus.alu_wdata = alu_wdata[g];
        assign bus.rf_busy   = rf_busy[g];
        assign bus.q_addr1   = q_addr1[g];
        assign bus.q_addr2   = q_addr2[g];
        assign mem_ready[g]  = bus.mem_ready;
        assign alu_ready[g]  = bus.alu_ready;
        assign rf_wen[g]     = bus.rf_wen;
        assign rf_waddr[g]   = bus.rf_waddr;
        assign rf_wdata[g]   = bus.rf_wdata;
        assign q_hit1[g]     = bus.q_hit1;
        assign q_data1[g]    = bus.q_data1;
        assign q_hit2[g]     = bus.q_hit2;
        assign q_data2[g]    = bus.q_data2;
        assign count[g]      = 4'(bus.count);
        regfile_wb_queue #(.DEPTH(D)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    end

    typedef struct {
        logic mv; logic [4:0] ma; logic [31:0] md;
        logic av; logic [4:0] aa; logic [31:0] ad;
        logic busy; logic [4:0] qa;
        logic emr; logic ear; logic [3:0] ecnt;
        logic ewen; logic [4:0] ewa; logic [31:0] ewd;
        logic ehit; logic [31:0] edat;
    } vec_t;

    vec_t tbl [NROW];
    int total = 0;
    int bad   = 0;

    wb_entry_t   mq   [NI][$];
    logic        m_wen [NI];
    logic [4:0]  m_wa  [NI];
    logic [31:0] m_wd  [NI];
    logic        hold_m [NI];
    logic        hold_a [NI];

    function automatic int dep(input int i);
        return (i == 0) ? 2 : (i == 1) ? 4 : 8;
    endfunction

    function automatic vec_t mk(
        input logic [31:0] mv, ma, md, av, aa, ad, busy, qa,
        input logic [31:0] emr, ear, ecnt, ewen, ewa, ewd, ehit, edat);
        vec_t v;
        v.mv = mv[0];   v.ma = 5'(ma);  v.md = md;
        v.av = av[0];   v.aa = 5'(aa);  v.ad = ad;
        v.busy = busy[0]; v.qa = 5'(qa);
        v.emr = emr[0]; v.ear = ear[0]; v.ecnt = 4'(ecnt);
        v.ewen = ewen[0]; v.ewa = 5'(ewa); v.ewd = ewd;
        v.ehit = ehit[0]; v.edat = edat;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic busy, input logic [4:0] qa1, input logic [4:0] qa2);
        mem_valid[i] = mv; mem_waddr[i] = ma; mem_wdata[i] = md;
        alu_valid[i] = av; alu_waddr[i] = aa; alu_wdata[i] = ad;
        rf_busy[i] = busy; q_addr1[i] = qa1; q_addr2[i] = qa2;
    endtask

    // Youngest pending value for address a: queue tail first, then the output stage.
    function automatic logic [32:0] fwd(input int i, input logic [4:0] a);
        if (a == 5'd0) return 33'(0);
        for (int k = mq[i].size() - 1; k >= 0; k--)
            if (mq[i][k].addr == a) return {1'b1, mq[i][k].data};
        if (m_wen[i] && (m_wa[i] == a)) return {1'b1, m_wd[i]};
        return 33'(0);
    endfunction

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) drive(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        q_addr1[DIR] = 5'd5;
        q_addr2[DIR] = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        check("reset count", 32'(count[DIR]), 0);
        check("reset rf_wen", 32'(rf_wen[DIR]), 0);
        check("reset rf_waddr", 32'(rf_waddr[DIR]), 0);
        check("reset rf_wdata", rf_wdata[DIR], 0);
        check("reset q_hit1", 32'(q_hit1[DIR]), 0);
        check("reset q_data1", q_data1[DIR], 0);
        rst = 1'b0;

        //             mv ma md            av aa ad            bsy qa  mr ar cnt wen wa wd            hit dat
        tbl[0]  = mk(0, 0, 0,            1, 5, 32'h00001234, 0, 5,  1, 1, 0, 0, 0, 0,            0, 0);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,            0, 5,  1, 1, 1, 0, 0, 0,            1, 32'h00001234);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,            0, 5,  1, 1, 0, 1, 5, 32'h00001234, 1, 32'h00001234);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,            0, 5,  1, 1, 0, 0, 5, 32'h00001234, 0, 0);
        tbl[4]  = mk(1, 3, 32'hAAAA0000, 1, 3, 32'h0000BBBB, 0, 3,  1, 1, 0, 0, 5, 32'h00001234, 0, 0);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,            0, 3,  1, 1, 2, 0, 5, 32'h00001234, 1, 32'h0000BBBB);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0,            0, 3,  1, 1, 1, 1, 3, 32'hAAAA0000, 1, 32'h0000BBBB);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,            0, 3,  1, 1, 0, 1, 3, 32'h0000BBBB, 1, 32'h0000BBBB);
        tbl[8]  = mk(0, 0, 0,            0, 0, 0,            0, 3,  1, 1, 0, 0, 3, 32'h0000BBBB, 0, 0);
        tbl[9]  = mk(1, 1, 32'h11,       1, 2, 32'h22,       1, 1,  1, 1, 0, 0, 3, 32'h0000BBBB, 0, 0);
        tbl[10] = mk(1, 3, 32'h33,       0, 0, 0,            1, 1,  1, 1, 2, 0, 3, 32'h0000BBBB, 1, 32'h11);
        tbl[11] = mk(1, 4, 32'h44,       1, 5, 32'h55,       1, 2,  1, 0, 3, 0, 3, 32'h0000BBBB, 1, 32'h22);
        tbl[12] = mk(0, 6, 0,            1, 5, 32'h55,       1, 4,  0, 0, 4, 0, 3, 32'h0000BBBB, 1, 32'h44);
        tbl[13] = mk(0, 6, 0,            1, 5, 32'h55,       0, 5,  0, 0, 4, 0, 3, 32'h0000BBBB, 0, 0);
        tbl[14] = mk(0, 6, 0,            1, 5, 32'h55,       0, 1,  1, 1, 3, 1, 1, 32'h11,       1, 32'h11);
        tbl[15] = mk(0, 0, 0,            0, 0, 0,            0, 5,  1, 1, 3, 1, 2, 32'h22,       1, 32'h55);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,            0, 2,  1, 1, 2, 1, 3, 32'h33,       0, 0);
        tbl[17] = mk(0, 0, 0,            0, 0, 0,            0, 4,  1, 1, 1, 1, 4, 32'h44,       1, 32'h44);
        tbl[18] = mk(0, 0, 0,            0, 0, 0,            0, 5,  1, 1, 0, 1, 5, 32'h55,       1, 32'h55);
        tbl[19] = mk(0, 0, 0,            0, 0, 0,            0, 5,  1, 1, 0, 0, 5, 32'h55,       0, 0);
        tbl[20] = mk(0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 0,  1, 1, 0, 0, 5, 32'h55,       0, 0);
        tbl[21] = mk(0, 0, 0,            0, 0, 0,            0, 0,  1, 1, 0, 0, 5, 32'h55,       0, 0);
        tbl[22] = mk(1, 1, 32'h101,      1, 2, 32'h102,      0, 3,  1, 1, 0, 0, 5, 32'h55,       0, 0);
        tbl[23] = mk(1, 3, 32'h103,      1, 4, 32'h104,      0, 3,  1, 1, 2, 0, 5, 32'h55,       0, 0);

        for (int r = 0; r < NROW; r++) begin
            string t;
            @(posedge clk);
            #1;
            drive(DIR, tbl[r].mv, tbl[r].ma, tbl[r].md, tbl[r].av, tbl[r].aa, tbl[r].ad,
                  tbl[r].busy, tbl[r].qa, tbl[r].qa);
            #2;
            t = $sformatf("row%0d", r);
            check({t, " mem_ready"}, 32'(mem_ready[DIR]), 32'(tbl[r].emr));
            check({t, " alu_ready"}, 32'(alu_ready[DIR]), 32'(tbl[r].ear));
            check({t, " count"}, 32'(count[DIR]), 32'(tbl[r].ecnt));
            check({t, " rf_wen"}, 32'(rf_wen[DIR]), 32'(tbl[r].ewen));
            check({t, " rf_waddr"}, 32'(rf_waddr[DIR]), 32'(tbl[r].ewa));
            check({t, " rf_wdata"}, rf_wdata[DIR], tbl[r].ewd);
            check({t, " q_hit1"}, 32'(q_hit1[DIR]), 32'(tbl[r].ehit));
            check({t, " q_data1"}, q_data1[DIR], tbl[r].edat);
            check({t, " q_hit2"}, 32'(q_hit2[DIR]), 32'(tbl[r].ehit));
            check({t, " q_data2"}, q_data2[DIR], tbl[r].edat);
        end

        // Asynchronous reset in the middle of a cycle with three entries queued and a write out.
        @(posedge clk);
        #1;
        drive(DIR, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        #1;
        check("pre-rst count", 32'(count[DIR]), 3);
        check("pre-rst rf_wen", 32'(rf_wen[DIR]), 1);
        check("pre-rst rf_wdata", rf_wdata[DIR], 32'h101);
        check("pre-rst q_data1", q_data1[DIR], 32'h103);
        rst = 1'b1;
        #1;
        check("async rst count", 32'(count[DIR]), 0);
        check("async rst rf_wen", 32'(rf_wen[DIR]), 0);
        check("async rst rf_waddr", 32'(rf_waddr[DIR]), 0);
        check("async rst rf_wdata", rf_wdata[DIR], 0);
        check("async rst q_hit1", 32'(q_hit1[DIR]), 0);
        check("async rst q_hit2", 32'(q_hit2[DIR]), 0);
        check("async rst q_data1", q_data1[DIR], 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #3;
        check("post-rst count", 32'(count[DIR]), 0);
        check("post-rst rf_wen", 32'(rf_wen[DIR]), 0);
        check("post-rst q_hit1", 32'(q_hit1[DIR]), 0);

        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            m_wen[i] = 1'b0; m_wa[i] = 5'd0; m_wd[i] = 32'd0;
            hold_m[i] = 1'b0; hold_a[i] = 1'b0;
        end

        for (int c = 0; c < NCYC; c++) begin
            int vp;
            vp = (((c / 1500) % 2) == 1) ? 3 : 7;
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (!hold_m[i]) begin
                    mem_valid[i] = $urandom_range(0, 9) < vp;
                    mem_waddr[i] = 5'($urandom_range(0, 7));
                    mem_wdata[i] = $urandom;
                end
                if (!hold_a[i]) begin
                    alu_valid[i] = $urandom_range(0, 9) < vp;
                    alu_waddr[i] = 5'($urandom_range(0, 7));
                    alu_wdata[i] = $urandom;
                end
                rf_busy[i] = $urandom_range(0, 3) == 0;
                q_addr1[i] = 5'($urandom_range(0, 7));
                q_addr2[i] = 5'($urandom_range(0, 7));
            end
            #2;
            for (int i = 0; i < NI; i++) begin
                int free;
                logic emr, ear, macc, aacc;
                logic [32:0] f1, f2;
                string t;
                wb_entry_t e;
                t    = $sformatf("rnd d%0d c%0d", dep(i), c);
                free = dep(i) - mq[i].size();
                emr  = (mem_waddr[i] == 5'd0) || (free >= 1);
                ear  = (alu_waddr[i] == 5'd0) || (free >= 2) ||
                       ((free == 1) && !(mem_valid[i] && (mem_waddr[i] != 5'd0)));
                f1   = fwd(i, q_addr1[i]);
                f2   = fwd(i, q_addr2[i]);
                check({t, " mem_ready"}, 32'(mem_ready[i]), 32'(emr));
                check({t, " alu_ready"}, 32'(alu_ready[i]), 32'(ear));
                check({t, " count"}, 32'(count[i]), 32'(mq[i].size()));
                check({t, " rf_wen"}, 32'(rf_wen[i]), 32'(m_wen[i]));
                check({t, " rf_waddr"}, 32'(rf_waddr[i]), 32'(m_wa[i]));
                check({t, " rf_wdata"}, rf_wdata[i], m_wd[i]);
                check({t, " q_hit1"}, 32'(q_hit1[i]), 32'(f1[32]));
                check({t, " q_data1"}, q_data1[i], f1[31:0]);
                check({t, " q_hit2"}, 32'(q_hit2[i]), 32'(f2[32]));
                check({t, " q_data2"}, q_data2[i], f2[31:0]);

                macc = mem_valid[i] && emr;
                aacc = alu_valid[i] && ear;
                if ((mq[i].size() > 0) && !rf_busy[i]) begin
                    e = mq[i].pop_front();
                    m_wen[i] = 1'b1; m_wa[i] = e.addr; m_wd[i] = e.data;
                end else begin
                    m_wen[i] = 1'b0;
                end
                if (macc && (mem_waddr[i] != 5'd0))
                    mq[i].push_back('{addr: mem_waddr[i], data: mem_wdata[i]});
                if (aacc && (alu_waddr[i] != 5'd0))
                    mq[i].push_back('{addr: alu_waddr[i], data: alu_wdata[i]});
                hold_m[i] = mem_valid[i] && !macc;
                hold_a[i] = alu_valid[i] && !aacc;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
